crossing_scheduler: RTL and testbench

Phase scheduler for a two-street intersection with a pedestrian crossing and emergency-vehicle preemption. It owns the shared crossing: it decides which of street A, street B or pedestrians holds the intersection, enforces minimum and maximum green, yellow and all-red clearance times, and drives both lamp sets plus the walk signal. Timing is counted in ticks from an external timebase strobe (1 tick = 1 s in the system), so the block runs on the fast system clock.

---
 rtl/crossing_pkg.sv | 38 +++
 rtl/dwell_counter.sv | 22 ++
 rtl/crossing_scheduler.sv | 146 ++++++++++++++
 tb/tb_crossing_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared phase encoding, lamp patterns and lamp decode helpers for the crossing scheduler.
package crossing_pkg;

    typedef enum logic [2:0] {
        PH_GREEN_A  = 3'd0,
        PH_YELLOW_A = 3'd1,
        PH_ALL_RED  = 3'd2,
        PH_GREEN_B  = 3'd3,
        PH_YELLOW_B = 3'd4,
        PH_WALK     = 3'd5
    } phase_e;

    typedef enum logic {
        DIR_A = 1'b0,
        DIR_B = 1'b1
    } dir_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [2:0] lampA(input phase_e p);
        case (p)
            PH_GREEN_A:  return LAMP_G;
            PH_YELLOW_A: return LAMP_Y;
            default:     return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] lampB(input phase_e p);
        case (p)
            PH_GREEN_B:  return LAMP_G;
            PH_YELLOW_B: return LAMP_Y;
            default:     return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating tick counter measuring time spent in the current phase.
module dwell_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/crossing_scheduler.sv
// Intersection phase scheduler: street A/B greens, pedestrian walk and emergency preemption.
module crossing_scheduler
    import crossing_pkg::*;
#(
    parameter int unsigned MIN_GREEN = 3,
    parameter int unsigned MAX_GREEN = 8,
    parameter int unsigned YELLOW    = 2,
    parameter int unsigned ALLRED    = 1,
    parameter int unsigned WALK      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
    input  logic       emerg_a,
    input  logic       emerg_b,
    output logic [2:0] la,
    output logic [2:0] lb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam int unsigned MAX_GY    = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
    localparam int unsigned MAX_AW    = (ALLRED > WALK) ? ALLRED : WALK;
    localparam int unsigned MAX_DWELL = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
    localparam int unsigned CW        = $clog2(MAX_DWELL + 1);
    localparam int unsigned CPW       = CW + 1;

    phase_e          phaseQ;
    phase_e          phaseD;
    phase_e          dirGreen;
    dir_e            nextDir;
    logic            pedPend;
    logic            walkEntry;
    logic [CW-1:0]   cnt;
    logic [CPW-1:0]  cntP1;
    logic            minOk;
    logic            maxOk;
    logic            yelOk;
    logic            arOk;
    logic            walkOk;

    dwell_counter #(.WIDTH(CW)) uDwell (
        .clk   (clk),
        .rst   (rst),
        .clear (phaseD != phaseQ),
        .tick  (tick),
        .count (cnt)
    );

    // Extra bit keeps cnt+1 from wrapping when cnt is saturated.
    assign cntP1  = CPW'(cnt) + CPW'(1);
    assign minOk  = tick && (cntP1 >= CPW'(MIN_GREEN));
    assign maxOk  = (cntP1 >= CPW'(MAX_GREEN));
    assign yelOk  = tick && (cntP1 >= CPW'(YELLOW));
    assign arOk   = tick && (cntP1 >= CPW'(ALLRED));
    assign walkOk = tick && (cntP1 >= CPW'(WALK));

    assign dirGreen  = (nextDir == DIR_A) ? PH_GREEN_A : PH_GREEN_B;
    assign walkEntry = (phaseD == PH_WALK) && (phaseQ != PH_WALK);
    assign phase     = phaseQ;

    // Next-phase selection.
    always_comb begin
        phaseD = phaseQ;
        case (phaseQ)
            PH_GREEN_A: begin
                if (!emerg_a) begin
                    if (emerg_b) begin
                        phaseD = PH_YELLOW_A;
                    end else if (minOk && (tb || pedPend) && (!ta || maxOk)) begin
                        phaseD = PH_YELLOW_A;
                    end
                end
            end
            PH_GREEN_B: begin
                if (!emerg_b) begin
                    if (emerg_a) begin
                        phaseD = PH_YELLOW_B;
                    end else if (minOk && (ta || pedPend) && (!tb || maxOk)) begin
                        phaseD = PH_YELLOW_B;
                    end
                end
            end
            PH_YELLOW_A, PH_YELLOW_B: begin
                if (yelOk) begin
                    phaseD = PH_ALL_RED;
                end
            end
            PH_ALL_RED: begin
                if (arOk) begin
                    if (emerg_a) begin
                        phaseD = PH_GREEN_A;
                    end else if (emerg_b) begin
                        phaseD = PH_GREEN_B;
                    end else if (pedPend) begin
                        phaseD = PH_WALK;
                    end else begin
                        phaseD = dirGreen;
                    end
                end
            end
            PH_WALK: begin
                if (emerg_a || emerg_b) begin
                    phaseD = PH_ALL_RED;
                end else if (walkOk) begin
                    phaseD = dirGreen;
                end
            end
            default: phaseD = PH_GREEN_A;
        endcase
    end

    // Phase register plus flops that track it; lamps are loaded from the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phaseQ  <= PH_GREEN_A;
            nextDir <= DIR_B;
            pedPend <= 1'b0;
            la      <= LAMP_G;
            lb      <= LAMP_R;
            walk    <= 1'b0;
            ped_ack <= 1'b0;
        end else begin
            phaseQ <= phaseD;
            if ((phaseQ == PH_YELLOW_A) && (phaseD == PH_ALL_RED)) begin
                nextDir <= DIR_B;
            end else if ((phaseQ == PH_YELLOW_B) && (phaseD == PH_ALL_RED)) begin
                nextDir <= DIR_A;
            end
            if (walkEntry) begin
                pedPend <= 1'b0;
            end else if (ped_req && (phaseQ != PH_WALK)) begin
                pedPend <= 1'b1;
            end
            la      <= lampA(phaseD);
            lb      <= lampB(phaseD);
            walk    <= (phaseD == PH_WALK);
            ped_ack <= walkEntry;
        end
    end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler with a queue of expected phase/lamp states.
module tb_crossing_scheduler;
    import crossing_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ta;
    logic       tb;
    logic       ped_req;
    logic       emerg_a;
    logic       emerg_b;
    logic [2:0] la;
    logic [2:0] lb;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        string      tag;
        logic [2:0] ph;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    crossing_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .ta      (ta),
        .tb      (tb),
        .ped_req (ped_req),
        .emerg_a (emerg_a),
        .emerg_b (emerg_b),
        .la      (la),
        .lb      (lb),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    // Expected {la, lb} for each phase.
    function automatic logic [5:0] lampsOf(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [2:0] ph, input logic ack);
        exp_t e;
        e.tag = tag;
        e.ph  = ph;
        e.ack = ack;
        sb.push_back(e);
    endtask

    task automatic checkOut();
        exp_t       e;
        logic [5:0] lm;
        total++;
        assert (sb.size() != 0) passed++;
        else begin
            failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() != 0) begin
            e  = sb.pop_front();
            lm = lampsOf(e.ph);
            cmp({e.tag, "/phase"}, phase, e.ph);
            cmp({e.tag, "/la"}, la, lm[5:3]);
            cmp({e.tag, "/lb"}, lb, lm[2:0]);
            cmp({e.tag, "/walk"}, 3'(walk), 3'(e.ph == 3'd5));
            cmp({e.tag, "/ped_ack"}, 3'(ped_ack), 3'(e.ack));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick1();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick1();
            cyc(1);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic pulsePed();
        ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tick = 1'b0; ta = 1'b0; tb = 1'b0;
        ped_req = 1'b0; emerg_a = 1'b0; emerg_b = 1'b0;

        // Normal A-to-B handover with B demand only.
        resetDut();
        pushExp("reset", PH_GREEN_A, 1'b0); checkOut();
        tb = 1'b1;
        ticks(2); pushExp("s1_min_hold", PH_GREEN_A, 1'b0); checkOut();
        ticks(1); pushExp("s1_yellow", PH_YELLOW_A, 1'b0); checkOut();
        ticks(1); pushExp("s1_yellow_hold", PH_YELLOW_A, 1'b0); checkOut();
        ticks(1); pushExp("s1_allred", PH_ALL_RED, 1'b0); checkOut();
        ticks(1); pushExp("s1_green_b", PH_GREEN_B, 1'b0); checkOut();

        // Both streets busy: A forced off at MAX_GREEN.
        tb = 1'b0;
        resetDut();
        ta = 1'b1; tb = 1'b1;
        ticks(7); pushExp("s2_hold7", PH_GREEN_A, 1'b0); checkOut();
        ticks(1); pushExp("s2_max", PH_YELLOW_A, 1'b0); checkOut();

        // Pedestrian cycle.
        ta = 1'b0; tb = 1'b0;
        resetDut();
        pulsePed();
        ticks(2); pushExp("s3_min_hold", PH_GREEN_A, 1'b0); checkOut();
        ticks(1); pushExp("s3_yellow", PH_YELLOW_A, 1'b0); checkOut();
        ticks(2); pushExp("s3_allred", PH_ALL_RED, 1'b0); checkOut();
        tick1(); pushExp("s3_walk_entry", PH_WALK, 1'b1); checkOut();
        cyc(1); pushExp("s3_ack_once", PH_WALK, 1'b0); checkOut();
        ticks(3); pushExp("s3_walk_hold", PH_WALK, 1'b0); checkOut();
        ticks(1); pushExp("s3_green_b", PH_GREEN_B, 1'b0); checkOut();

        // Emergency on A preempts GREEN_B at cnt=0 without a tick.
        emerg_a = 1'b1;
        cyc(1); pushExp("s4_preempt", PH_YELLOW_B, 1'b0); checkOut();
        ticks(2); pushExp("s4_allred", PH_ALL_RED, 1'b0); checkOut();
        ticks(1); pushExp("s4_green_a", PH_GREEN_A, 1'b0); checkOut();
        emerg_b = 1'b1;
        ticks(4); pushExp("s4_both_emerg", PH_GREEN_A, 1'b0); checkOut();
        emerg_a = 1'b0; emerg_b = 1'b0;

        // Emergency on B aborts WALK.
        resetDut();
        pulsePed();
        ticks(3); ticks(2); ticks(1);
        pushExp("s5_walk", PH_WALK, 1'b0); checkOut();
        emerg_b = 1'b1;
        cyc(1); pushExp("s5_abort", PH_ALL_RED, 1'b0); checkOut();
        ticks(1); pushExp("s5_green_b", PH_GREEN_B, 1'b0); checkOut();

        // Reset in YELLOW_B with a pending pedestrian request.
        emerg_b = 1'b0; ta = 1'b1; tb = 1'b0;
        ticks(3); pushExp("s6_yellow_b", PH_YELLOW_B, 1'b0); checkOut();
        pulsePed();
        #2 rst = 1'b1;
        #1 pushExp("s6_async_rst", PH_GREEN_A, 1'b0); checkOut();
        rst = 1'b0;
        ta = 1'b0;
        cyc(1);
        ticks(6); pushExp("s6_no_walk", PH_GREEN_A, 1'b0); checkOut();

        // Idle green: counter saturates rather than wrapping.
        ticks(10);
        tb = 1'b1;
        ticks(1); pushExp("s7_saturated", PH_YELLOW_A, 1'b0); checkOut();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
